// File: rtl/nios2_debug_ocimem_ctrl.sv
// nios2_debug_ocimem_ctrl
//   Monitor-RAM controller for the Nios II JTAG debug path. Accepts the take_*_ocimem_* command
//   pulses from the sysclk stage into a one-entry pending register, runs word reads and writes
//   against a local 32-bit RAM, and reports MonDReg/monitor_ready/monitor_error back. The same
//   RAM is visible to the CPU through an Avalon-MM slave; debug commands win arbitration.
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   jdo                             JTAG data word (address in [26+:ADDR_W], data in [34:3])
//   take_action_ocimem_a            load address then read
//   take_no_action_ocimem_a         read at MonAReg then increment
//   take_action_ocimem_b            write at MonAReg then increment
//   avs_*                           Avalon-MM slave (word addressed, byte enables)
//   MonDReg, monitor_ready,
//   monitor_error                   debug read data, command done, sticky error
module nios2_debug_ocimem_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAP_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle, StDbgRd, StDbgCap, StDbgWr, StAvsRd, StAvsDone
    } state_e;

    typedef enum logic [1:0] {
        CmdNone, CmdRdA, CmdRdNa, CmdWr
    } cmd_e;

    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    cmd_e              pend_cmd_q, pend_cmd_d;
    logic [37:0]       pend_jdo_q, pend_jdo_d;
    cmd_e              cur_cmd_q, cur_cmd_d;
    logic [31:0]       cur_data_q, cur_data_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              avs_done_q, avs_done_d;

    logic [31:0]       mem [Depth];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;

    cmd_e              new_cmd;
    logic              consume;
    logic              out_of_range;

    assign out_of_range    = 32'(mon_a_q) >= MAP_WORDS;
    assign consume         = (state_q == StIdle) && pend_valid_q;
    assign avs_waitrequest = (avs_read | avs_write) & ~avs_done_q;
    assign avs_readdata    = readdata_q;
    assign MonDReg         = mon_d_q;
    assign monitor_ready   = ready_q;
    assign monitor_error   = error_q;

    always_comb begin
        new_cmd = CmdNone;
        if (take_action_ocimem_a)         new_cmd = CmdRdA;
        else if (take_action_ocimem_b)    new_cmd = CmdWr;
        else if (take_no_action_ocimem_a) new_cmd = CmdRdNa;
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        pend_jdo_d   = pend_jdo_q;
        cur_cmd_d    = cur_cmd_q;
        cur_data_d   = cur_data_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        ready_d      = ready_q;
        error_d      = error_q;
        readdata_d   = readdata_q;
        avs_done_d   = 1'b0;
        ram_addr     = mon_a_q;
        ram_we       = 1'b0;
        ram_be       = 4'hF;
        ram_wdata    = cur_data_q;

        unique case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    pend_valid_d = 1'b0;
                    cur_cmd_d    = pend_cmd_q;
                    cur_data_d   = pend_jdo_q[34:3];
                    if (pend_cmd_q == CmdRdA) mon_a_d = pend_jdo_q[26 +: ADDR_W];
                    state_d = (pend_cmd_q == CmdWr) ? StDbgWr : StDbgRd;
                // A debug pulse arriving this cycle holds off a new CPU access so the
                // debug command is served first; avs_done_q masks the request the master
                // is still holding during its completion cycle.
                end else if (new_cmd == CmdNone && !avs_done_q) begin
                    if (avs_read) begin
                        state_d = StAvsRd;
                    end else if (avs_write) begin
                        ram_addr   = avs_address;
                        ram_we     = 1'b1;
                        ram_be     = avs_byteenable;
                        ram_wdata  = avs_writedata;
                        avs_done_d = 1'b1;
                    end
                end
            end
            StDbgRd: begin
                ram_addr = mon_a_q;
                state_d  = StDbgCap;
            end
            StDbgCap: begin
                if (out_of_range) begin
                    mon_d_d = 32'h0;
                    error_d = 1'b1;
                end else begin
                    mon_d_d = ram_q;
                end
                ready_d = 1'b1;
                if (cur_cmd_q == CmdRdNa) mon_a_d = mon_a_q + ADDR_W'(1);
                state_d = StIdle;
            end
            StDbgWr: begin
                if (out_of_range) error_d = 1'b1;
                else              ram_we  = 1'b1;
                ready_d = 1'b1;
                mon_a_d = mon_a_q + ADDR_W'(1);
                state_d = StIdle;
            end
            StAvsRd: begin
                ram_addr = avs_address;
                state_d  = StAvsDone;
            end
            StAvsDone: begin
                readdata_d = ram_q;
                avs_done_d = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Command intake: a slot is free if empty or being consumed this same cycle.
        if (new_cmd != CmdNone) begin
            if (!pend_valid_q || consume) begin
                pend_valid_d = 1'b1;
                pend_cmd_d   = new_cmd;
                pend_jdo_d   = jdo;
                ready_d      = 1'b0;
                if (new_cmd == CmdRdA) error_d = 1'b0;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= CmdNone;
            pend_jdo_q   <= '0;
            cur_cmd_q    <= CmdNone;
            cur_data_q   <= '0;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            readdata_q   <= '0;
            avs_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_cmd_q   <= pend_cmd_d;
            pend_jdo_q   <= pend_jdo_d;
            cur_cmd_q    <= cur_cmd_d;
            cur_data_q   <= cur_data_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            ready_q      <= ready_d;
            error_q      <= error_d;
            readdata_q   <= readdata_d;
            avs_done_q   <= avs_done_d;
        end
    end

    // Contents are not reset; writes are suppressed while reset is asserted so an
    // aborted operation cannot corrupt a word.
    always_ff @(posedge clk) begin
        if (ram_we && reset_n) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        ram_q <= mem[ram_addr];
    end

endmodule
